// File: rtl/misc_multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the KGP miniRISC datapath.
// Build option: define MISC_ILLEGAL_TRAP_EN to trap illegal opcodes (adds the illegal_op port).
module misc_multicycle_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [4:0]       func,
    input  logic             zero_flag,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             wb_src,
    output logic             alu_src,
    output logic             imm_zext,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retire_cnt
`ifdef MISC_ILLEGAL_TRAP_EN
    ,
    output logic             illegal_op
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;

    localparam logic [5:0] OP_RALU  = 6'b000000;
    localparam logic [5:0] OP_IALU  = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b000100;
    localparam logic [5:0] OP_BZ    = 6'b000101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam int            TW       = (MEM_TIMEOUT < 32'sd2) ? 32'sd1 : $clog2(MEM_TIMEOUT + 32'sd1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 32'sd1);
    localparam logic          TMO_EN   = (MEM_TIMEOUT > 32'sd0);

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RALU, OP_IALU, OP_SHIFT, OP_LW, OP_SW, OP_BZ, OP_HALT: is_legal = 1'b1;
            default:                                                 is_legal = 1'b0;
        endcase
    endfunction

    state_t        state_r;
    state_t        nxt_s;
    logic [5:0]    op_r;
    logic [5:0]    op_s;
    logic [TW-1:0] tmo_cnt_r;
    logic          wait_s;
    logic          timeout_s;
    logic          retire_s;
    logic          unused_func_s;

    // The function field only matters to the ALU control, not to sequencing.
    assign unused_func_s = ^func;

    // The opcode is captured in DECODE and held for the rest of the instruction.
    assign op_s      = (state_r == DECODE) ? opcode : op_r;
    assign wait_s    = mem_req && !mem_ack;
    assign timeout_s = TMO_EN && wait_s && (tmo_cnt_r == TMO_LAST);

    // Mealy strobes qualified by the memory handshake and the ALU zero flag.
    assign ir_write = (state_r == FETCH) && mem_ack;
    assign pc_write = ir_write || ((state_r == EXEC) && (op_r == OP_BZ) && zero_flag);
    assign imm_zext = ((state_r == DECODE) || (state_r == EXEC)) && (opcode == OP_SHIFT);

    // Next-state and retire decode.
    always_comb begin
        nxt_s    = state_r;
        retire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) nxt_s = FETCH;
                else       nxt_s = IDLE;
            end
            FETCH: begin
                if (mem_ack)        nxt_s = DECODE;
                else if (timeout_s) nxt_s = HALT;
                else                nxt_s = FETCH;
            end
            DECODE: begin
                if (op_s == OP_HALT) begin
                    nxt_s = HALT;
                end else if (!is_legal(op_s)) begin
`ifdef MISC_ILLEGAL_TRAP_EN
                    nxt_s = TRAP;
`else
                    nxt_s    = FETCH;
                    retire_s = 1'b1;
`endif
                end else begin
                    nxt_s = EXEC;
                end
            end
            EXEC: begin
                case (op_s)
                    OP_LW, OP_SW: nxt_s = MEM;
                    OP_BZ: begin
                        nxt_s    = FETCH;
                        retire_s = 1'b1;
                    end
                    default:      nxt_s = WB;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op_s == OP_SW) begin
                        nxt_s    = FETCH;
                        retire_s = 1'b1;
                    end else begin
                        nxt_s = WB;
                    end
                end else if (timeout_s) begin
                    nxt_s = HALT;
                end else begin
                    nxt_s = MEM;
                end
            end
            WB: begin
                nxt_s    = FETCH;
                retire_s = 1'b1;
            end
            HALT:    nxt_s = HALT;
            TRAP:    nxt_s = TRAP;
            default: nxt_s = IDLE;
        endcase
    end

    // State register plus Moore outputs registered from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            op_r       <= 6'b000000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            iord       <= 1'b0;
            pc_src     <= 1'b0;
            reg_write  <= 1'b0;
            wb_src     <= 1'b0;
            alu_src    <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            mem_err    <= 1'b0;
`ifdef MISC_ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            state_r    <= nxt_s;
            op_r       <= op_s;
            mem_req    <= (nxt_s == FETCH) || (nxt_s == MEM);
            mem_we     <= (nxt_s == MEM) && (op_s == OP_SW);
            iord       <= (nxt_s == MEM);
            pc_src     <= (nxt_s == EXEC) && (op_s == OP_BZ);
            reg_write  <= (nxt_s == WB);
            wb_src     <= (nxt_s == WB) && (op_s == OP_LW);
            alu_src    <= (nxt_s == EXEC) && (op_s inside {OP_IALU, OP_SHIFT, OP_LW, OP_SW});
            busy       <= !(nxt_s inside {IDLE, HALT, TRAP});
            halted     <= (nxt_s == HALT) || (nxt_s == TRAP);
            mem_err    <= mem_err || timeout_s;
`ifdef MISC_ILLEGAL_TRAP_EN
            illegal_op <= (nxt_s == TRAP);
`endif
        end
    end

    // Wait counter restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= '0;
        end else if (nxt_s != state_r) begin
            tmo_cnt_r <= '0;
        end else if (wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (retire_s) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end else begin
            retire_cnt <= retire_cnt;
        end
    end

endmodule
